// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: single-cycle cache hits, four-byte little-endian
// memory refill on a miss (with cache fill), and flush-driven abort of any fetch.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic              flush_i,
  output logic              if_ready_o,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              cache_query_o,
  output logic [ADDR_W-1:0] query_addr_o,
  input  logic              inst_hit_i,
  input  logic [INST_W-1:0] inst_cache_i,
  output logic              cache_enable_o,
  output logic [ADDR_W-1:0] cache_addr_o,
  output logic [INST_W-1:0] cache_data_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_grant_i,
  input  logic [7:0]        mem_rdata_i
);

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_pc_lat;
  logic [23:0]       r_asm;
  logic              r_inst_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_cache_en;
  logic [ADDR_W-1:0] r_cache_addr;
  logic [INST_W-1:0] r_cache_data;

  logic [ADDR_W-1:0] w_pc_a;
  logic              w_accept;
  logic              w_fwd;
  logic              w_hit;
  logic [INST_W-1:0] w_hit_data;
  logic              w_mem_req;
  logic              w_issue;
  logic              w_last_capture;
  logic [INST_W-1:0] w_word;

  assign w_pc_a   = if_pc_i & ALIGN_MASK;
  assign w_accept = (r_state == IDLE) && if_req_i && !flush_i;

  // A fill registered last edge is not yet visible in the cache array, so bypass it.
  assign w_fwd      = r_cache_en && (r_cache_addr == w_pc_a);
  assign w_hit      = w_fwd || inst_hit_i;
  assign w_hit_data = w_fwd ? r_cache_data : inst_cache_i;

  assign w_mem_req      = (r_state == FETCH) && (r_cnt < 3'd4) && !flush_i;
  assign w_issue        = w_mem_req && mem_grant_i;
  assign w_last_capture = (r_state == FETCH) && r_rd_pend && (r_cnt == 3'd4);
  assign w_word         = {mem_rdata_i, r_asm};

  assign if_ready_o    = (r_state == IDLE);
  assign cache_query_o = w_accept;
  assign query_addr_o  = w_accept ? w_pc_a : '0;
  assign mem_req_o     = w_mem_req;
  assign mem_addr_o    = w_mem_req ? (r_pc_lat + ADDR_W'(r_cnt)) : '0;

  assign inst_valid_o   = r_inst_valid;
  assign inst_o         = r_inst;
  assign inst_pc_o      = r_inst_pc;
  assign cache_enable_o = r_cache_en;
  assign cache_addr_o   = r_cache_addr;
  assign cache_data_o   = r_cache_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rd_pend    <= 1'b0;
      r_pc_lat     <= '0;
      r_asm        <= '0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_cache_en   <= 1'b0;
      r_cache_addr <= '0;
      r_cache_data <= '0;
    end else begin
      r_inst_valid <= 1'b0;
      r_cache_en   <= 1'b0;
      if (flush_i) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_rd_pend <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              if (w_hit) begin
                r_inst_valid <= 1'b1;
                r_inst       <= w_hit_data;
                r_inst_pc    <= w_pc_a;
              end else begin
                r_pc_lat  <= w_pc_a;
                r_cnt     <= '0;
                r_rd_pend <= 1'b0;
                r_state   <= FETCH;
              end
            end
          end
          FETCH: begin
            if (w_issue) r_cnt <= r_cnt + 3'd1;
            r_rd_pend <= w_issue;
            // Byte (cnt-1) arrives the cycle after its issue; byte 3 goes straight out.
            if (r_rd_pend) begin
              case (r_cnt)
                3'd1:    r_asm[7:0]   <= mem_rdata_i;
                3'd2:    r_asm[15:8]  <= mem_rdata_i;
                3'd3:    r_asm[23:16] <= mem_rdata_i;
                default: ;
              endcase
            end
            if (w_last_capture) begin
              r_inst_valid <= 1'b1;
              r_inst       <= w_word;
              r_inst_pc    <= r_pc_lat;
              r_cache_en   <= 1'b1;
              r_cache_addr <= r_pc_lat;
              r_cache_data <= w_word;
              r_cnt        <= '0;
              r_rd_pend    <= 1'b0;
              r_state      <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed corner sequences, a hit
// vector table and a randomized run against a transaction-level model.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_pc_i;
  logic        flush_i;
  logic        if_ready_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        cache_query_o;
  logic [31:0] query_addr_o;
  logic        inst_hit_i;
  logic [31:0] inst_cache_i;
  logic        cache_enable_o;
  logic [31:0] cache_addr_o;
  logic [31:0] cache_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_rdata_i;

  inst_fetch_ctrl #(.ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_pc_i(if_pc_i), .flush_i(flush_i),
    .if_ready_o(if_ready_o), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .cache_query_o(cache_query_o), .query_addr_o(query_addr_o),
    .inst_hit_i(inst_hit_i), .inst_cache_i(inst_cache_i),
    .cache_enable_o(cache_enable_o), .cache_addr_o(cache_addr_o),
    .cache_data_o(cache_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_grant_i(mem_grant_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  memArr [0:1023];
  logic [31:0] cacheMem [logic [31:0]];
  bit          known [logic [31:0]];
  bit          cacheOn = 1'b1;
  bit          fillPend = 1'b0;
  logic [31:0] fillAddr, fillData;

  // Byte memory: data appears exactly one cycle after a granted read, junk otherwise.
  always @(posedge clk) begin
    if (mem_req_o && mem_grant_i) mem_rdata_i <= memArr[mem_addr_o[9:0]];
    else                          mem_rdata_i <= 8'($urandom);
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    int b;
    b = int'(a[9:0]);
    return {memArr[b+3], memArr[b+2], memArr[b+1], memArr[b]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The cache array only sees a fill one edge after cache_enable_o is observed.
  task automatic nextCycle();
    @(negedge clk);
    if (fillPend) begin
      cacheMem[fillAddr] = fillData;
      fillPend = 1'b0;
    end
    if (cache_enable_o) begin
      fillPend = 1'b1;
      fillAddr = cache_addr_o;
      fillData = cache_data_o;
    end
  endtask

  task automatic applyStimulus(input bit req, input logic [31:0] pc, input bit fl, input bit gr);
    logic [31:0] pa;
    pa = pc & 32'hFFFF_FFFC;
    if_req_i = req;
    if_pc_i = pc;
    flush_i = fl;
    mem_grant_i = gr;
    if (cacheOn && req && cacheMem.exists(pa)) begin
      inst_hit_i = 1'b1;
      inst_cache_i = cacheMem[pa];
    end else begin
      inst_hit_i = 1'b0;
      inst_cache_i = $urandom;
    end
    #1;
  endtask

  task automatic fetchMiss(input logic [31:0] pc, input string tag);
    logic [31:0] pa;
    pa = pc & 32'hFFFF_FFFC;
    applyStimulus(1'b1, pc, 1'b0, 1'b1);
    checkOutput({tag, " query"}, 32'(cache_query_o), 32'd1);
    checkOutput({tag, " qaddr"}, query_addr_o, pa);
    for (int t = 0; t < 4; t++) begin
      nextCycle();
      applyStimulus(1'b0, pc, 1'b0, 1'b1);
      checkOutput({tag, " memreq"}, 32'(mem_req_o), 32'd1);
      checkOutput({tag, " memaddr"}, mem_addr_o, pa + 32'(t));
      checkOutput({tag, " early valid"}, 32'(inst_valid_o), 32'd0);
    end
    nextCycle();
    applyStimulus(1'b0, pc, 1'b0, 1'b1);
    checkOutput({tag, " memreq T5"}, 32'(mem_req_o), 32'd0);
    checkOutput({tag, " valid T5"}, 32'(inst_valid_o), 32'd0);
    nextCycle();
    checkOutput({tag, " valid"}, 32'(inst_valid_o), 32'd1);
    checkOutput({tag, " inst"}, inst_o, memWord(pa));
    checkOutput({tag, " pc"}, inst_pc_o, pa);
    checkOutput({tag, " fill en"}, 32'(cache_enable_o), 32'd1);
    checkOutput({tag, " fill addr"}, cache_addr_o, pa);
    checkOutput({tag, " fill data"}, cache_data_o, memWord(pa));
  endtask

  typedef struct {
    bit          req;
    bit          flush;
    logic [31:0] pc;
    bit          expQuery;
    logic [31:0] expQAddr;
    bit          expValid;
    logic [31:0] expPc;
  } hitVec_t;

  hitVec_t vecs [6];

  bit          mBusy, mFourth, eValid, eFill;
  int          mIssued;
  logic [31:0] mPc, eInst, ePc;

  initial begin
    bit req, fl, gr, accept, expMemReq;
    logic [31:0] pc, pa, expMemAddr;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h100};
    vecs[1] = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h103, 1'b1, 32'h100, 1'b1, 32'h100};
    vecs[3] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h101, 1'b1, 32'h100, 1'b1, 32'h100};
    vecs[5] = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 32'h0};

    for (int i = 0; i < 1024; i++) memArr[i] = 8'($urandom);
    memArr[256] = 8'h13;
    memArr[257] = 8'h05;
    memArr[258] = 8'h10;
    memArr[259] = 8'h00;

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    checkOutput("reset valid", 32'(inst_valid_o), 32'd0);
    checkOutput("reset inst", inst_o, 32'd0);
    checkOutput("reset fill en", 32'(cache_enable_o), 32'd0);
    checkOutput("reset ready", 32'(if_ready_o), 32'd1);
    checkOutput("reset memreq", 32'(mem_req_o), 32'd0);
    checkOutput("reset query", 32'(cache_query_o), 32'd0);

    fetchMiss(32'h100, "coldmiss");
    checkOutput("coldmiss word", inst_o, 32'h0010_0513);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("pulse valid drop", 32'(inst_valid_o), 32'd0);
    checkOutput("pulse fill drop", 32'(cache_enable_o), 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].req, vecs[i].pc, vecs[i].flush, 1'b1);
      checkOutput($sformatf("vec%0d query", i), 32'(cache_query_o), 32'(vecs[i].expQuery));
      checkOutput($sformatf("vec%0d qaddr", i), query_addr_o, vecs[i].expQAddr);
      checkOutput($sformatf("vec%0d memreq", i), 32'(mem_req_o), 32'd0);
      nextCycle();
      checkOutput($sformatf("vec%0d valid", i), 32'(inst_valid_o), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d inst", i), inst_o, 32'h0010_0513);
        checkOutput($sformatf("vec%0d pc", i), inst_pc_o, vecs[i].expPc);
      end
    end

    // Grant drops for three cycles right after byte 1 issues.
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b1);
    for (int t = 1; t <= 9; t++) begin
      nextCycle();
      gr = !(t >= 3 && t <= 5);
      applyStimulus(1'b0, 32'h104, 1'b0, gr);
      if (t <= 2) checkOutput("stall addr", mem_addr_o, 32'h104 + 32'(t - 1));
      if (t >= 3 && t <= 6) checkOutput("stall hold addr", mem_addr_o, 32'h106);
      if (t == 7) checkOutput("stall addr last", mem_addr_o, 32'h107);
      if (t <= 7) checkOutput("stall memreq", 32'(mem_req_o), 32'd1);
      checkOutput("stall valid timing", 32'(inst_valid_o), 32'(t == 9));
    end
    checkOutput("stall inst", inst_o, memWord(32'h104));
    checkOutput("stall fill", 32'(cache_enable_o), 32'd1);

    // Flush in the third cycle of a miss.
    nextCycle();
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h108, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h108, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h108, 1'b1, 1'b1);
    checkOutput("flush memreq", 32'(mem_req_o), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("flush ready", 32'(if_ready_o), 32'd1);
    for (int t = 0; t < 5; t++) begin
      checkOutput("flush no valid", 32'(inst_valid_o), 32'd0);
      checkOutput("flush no fill", 32'(cache_enable_o), 32'd0);
      checkOutput("flush no memreq", 32'(mem_req_o), 32'd0);
      nextCycle();
    end
    fetchMiss(32'h200, "postflush");

    // Request lands in the cycle the fill is being written.
    nextCycle();
    fetchMiss(32'h110, "fwdmiss");
    applyStimulus(1'b1, 32'h110, 1'b0, 1'b1);
    checkOutput("fwd query", 32'(cache_query_o), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("fwd valid", 32'(inst_valid_o), 32'd1);
    checkOutput("fwd inst", inst_o, memWord(32'h110));
    checkOutput("fwd pc", inst_pc_o, 32'h110);
    checkOutput("fwd memreq", 32'(mem_req_o), 32'd0);
    checkOutput("fwd ready", 32'(if_ready_o), 32'd1);

    // Flush on the byte-3 capture cycle.
    nextCycle();
    applyStimulus(1'b1, 32'h114, 1'b0, 1'b1);
    for (int t = 1; t <= 5; t++) begin
      nextCycle();
      applyStimulus(1'b0, 32'h114, t == 5, 1'b1);
    end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("flushdone valid", 32'(inst_valid_o), 32'd0);
    checkOutput("flushdone fill", 32'(cache_enable_o), 32'd0);
    checkOutput("flushdone ready", 32'(if_ready_o), 32'd1);

    cacheOn = 1'b0;
    nextCycle();
    fetchMiss(32'h102, "unaligned");
    cacheOn = 1'b1;

    // Reset in the middle of a fetch.
    nextCycle();
    applyStimulus(1'b1, 32'h126, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h126, 1'b0, 1'b1);
    checkOutput("rstmid memaddr", mem_addr_o, 32'h124);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h126, 1'b0, 1'b1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("rstmid valid", 32'(inst_valid_o), 32'd0);
    checkOutput("rstmid inst", inst_o, 32'd0);
    checkOutput("rstmid pc", inst_pc_o, 32'd0);
    checkOutput("rstmid fill addr", cache_addr_o, 32'd0);
    checkOutput("rstmid fill data", cache_data_o, 32'd0);
    checkOutput("rstmid ready", 32'(if_ready_o), 32'd1);
    checkOutput("rstmid memreq", 32'(mem_req_o), 32'd0);
    for (int t = 0; t < 6; t++) begin
      nextCycle();
      checkOutput("rstmid no fill", 32'(cache_enable_o), 32'd0);
      checkOutput("rstmid no valid", 32'(inst_valid_o), 32'd0);
    end

    // Randomized run: a miss costs four granted reads and delivers two cycles after the last.
    cacheMem.delete();
    fillPend = 1'b0;
    mBusy = 1'b0;
    mFourth = 1'b0;
    mIssued = 0;
    mPc = '0;
    eValid = 1'b0;
    eFill = 1'b0;
    eInst = '0;
    ePc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nextCycle();
      checkOutput("rand valid", 32'(inst_valid_o), 32'(eValid));
      if (eValid) begin
        checkOutput("rand inst", inst_o, eInst);
        checkOutput("rand pc", inst_pc_o, ePc);
      end
      checkOutput("rand fill en", 32'(cache_enable_o), 32'(eFill));
      if (eFill) begin
        checkOutput("rand fill addr", cache_addr_o, ePc);
        checkOutput("rand fill data", cache_data_o, eInst);
      end

      req = 1'($urandom_range(0, 1));
      pc = 32'h100 + 32'($urandom_range(0, 127));
      fl = ($urandom_range(0, 15) == 0);
      gr = ($urandom_range(0, 3) != 0);
      applyStimulus(req, pc, fl, gr);
      pa = pc & 32'hFFFF_FFFC;

      accept = !mBusy && req && !fl;
      expMemReq = mBusy && (mIssued < 4) && !fl;
      expMemAddr = expMemReq ? (mPc + 32'(mIssued)) : 32'd0;
      checkOutput("rand ready", 32'(if_ready_o), 32'(!mBusy));
      checkOutput("rand query", 32'(cache_query_o), 32'(accept));
      checkOutput("rand qaddr", query_addr_o, accept ? pa : 32'd0);
      checkOutput("rand memreq", 32'(mem_req_o), 32'(expMemReq));
      checkOutput("rand memaddr", mem_addr_o, expMemAddr);

      eValid = 1'b0;
      eFill = 1'b0;
      if (fl) begin
        mBusy = 1'b0;
        mIssued = 0;
        mFourth = 1'b0;
      end else if (accept) begin
        if (known.exists(pa)) begin
          eValid = 1'b1;
          eInst = memWord(pa);
          ePc = pa;
        end else begin
          mBusy = 1'b1;
          mPc = pa;
          mIssued = 0;
          mFourth = 1'b0;
        end
      end else if (mBusy) begin
        if (mFourth) begin
          eValid = 1'b1;
          eFill = 1'b1;
          eInst = memWord(mPc);
          ePc = mPc;
          known[mPc] = 1'b1;
          mBusy = 1'b0;
          mFourth = 1'b0;
        end else if (expMemReq && gr) begin
          mIssued++;
          mFourth = (mIssued == 4);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
